// File: rtl/soc_map_pkg.sv
// SoC address map shared by the data-side responder: MMIO page base, register
// offsets, default RAM depth and the byte-merge helper.
package soc_map_pkg;

  localparam logic [15:0] MMIO_BASE_DEF = 16'hBFAF;
  localparam int unsigned RAM_AW_DEF    = 14;

  localparam logic [15:0] LED_OFF    = 16'hF000;
  localparam logic [15:0] NUM_OFF    = 16'hF010;
  localparam logic [15:0] SWITCH_OFF = 16'hF020;
  localparam logic [15:0] TIMER_OFF  = 16'hE000;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LED,
    SEL_NUM,
    SEL_SWITCH,
    SEL_TIMER
  } mmioSel_e;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    for (int unsigned i = 0; i < 4; i++)
      merged[8*i +: 8] = wen[i] ? newWord[8*i +: 8] : oldWord[8*i +: 8];
    return merged;
  endfunction

endpackage

// File: rtl/sp_ram_bw.sv
// Single-port read-first RAM with per-byte write enables and a registered
// read port; contents are not reset.
module sp_ram_bw #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int unsigned i = 0; i < 4; i++)
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data-port responder: decodes each request to the byte-writable RAM or the
// MMIO page (LED, NUM, SWITCH, TIMER) and returns read data one cycle later.
module data_sram_responder
  import soc_map_pkg::*;
#(
  parameter int unsigned RAM_AW    = RAM_AW_DEF,
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  logic        isMmio;
  logic        wrEn;
  logic        ramEn;
  mmioSel_e    sel;
  logic [31:0] ledMerged;
  logic [31:0] timerNext;
  logic [31:0] mmioRdNext;
  logic [31:0] timer;
  logic [31:0] mmioRdata;
  logic [31:0] ramRdata;
  logic        rdRam;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^data_sram_addr[1:0];

  assign isMmio = (data_sram_addr[31:16] == MMIO_BASE);
  assign wrEn   = data_sram_en && (data_sram_wen != 4'h0);
  assign ramEn  = data_sram_en && !isMmio;

  always_comb begin
    sel = SEL_NONE;
    if (isMmio) begin
      unique case (data_sram_addr[15:0])
        LED_OFF:    sel = SEL_LED;
        NUM_OFF:    sel = SEL_NUM;
        SWITCH_OFF: sel = SEL_SWITCH;
        TIMER_OFF:  sel = SEL_TIMER;
        default:    sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    mmioRdNext = '0;
    unique case (sel)
      SEL_LED:    mmioRdNext = {16'h0000, led};
      SEL_NUM:    mmioRdNext = num_data;
      SEL_SWITCH: mmioRdNext = {24'h000000, switch};
      SEL_TIMER:  mmioRdNext = timer;
      default:    mmioRdNext = '0;
    endcase
  end

  assign ledMerged = mergeBytes({16'h0000, led}, data_sram_wdata, data_sram_wen);

  // Written timer bytes override; unwritten bytes keep counting.
  always_comb begin
    timerNext = timer + 32'd1;
    if (wrEn && sel == SEL_TIMER)
      timerNext = mergeBytes(timer + 32'd1, data_sram_wdata, data_sram_wen);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led       <= '0;
      num_data  <= '0;
      timer     <= '0;
      mmioRdata <= '0;
      rdRam     <= 1'b0;
    end else begin
      timer <= timerNext;
      if (data_sram_en) begin
        mmioRdata <= mmioRdNext;
        rdRam     <= !isMmio;
      end
      if (wrEn && sel == SEL_LED) led      <= ledMerged[15:0];
      if (wrEn && sel == SEL_NUM) num_data <= mergeBytes(num_data, data_sram_wdata, data_sram_wen);
    end
  end

  sp_ram_bw #(.AW(RAM_AW)) uRam (
    .clk   (clk),
    .en    (ramEn),
    .wen   (data_sram_wen),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ramRdata)
  );

  // Reset clears rdRam so the output shows the zeroed MMIO register.
  assign data_sram_rdata = rdRam ? ramRdata : mmioRdata;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: RAM, byte enables, aliasing,
// MMIO registers, timer and asynchronous reset.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] numData;

  int unsigned checkCnt = 0;
  int unsigned errCnt   = 0;

  data_sram_responder #(.RAM_AW(14), .MMIO_BASE(16'hBFAF)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (switch),
    .led             (led),
    .num_data        (numData)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Drive one request at the falling edge; returns at the next falling edge,
  // when rdata carries that request's response.
  task automatic access(input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic idle();
    access(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0; switch = 8'hA5;
    repeat (2) @(negedge clk);
    checkVal("rst_rdata", rdata, 32'h0);
    checkVal("rst_led", {16'h0, led}, 32'h0);
    checkVal("rst_num", numData, 32'h0);
    reset = 1'b0;

    repeat (10) idle();
    access(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
    checkVal("timer_10", rdata, 32'd10);

    access(1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678);
    access(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checkVal("ram_word", rdata, 32'h1234_5678);

    access(1'b1, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD);
    access(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checkVal("ram_bytes", rdata, 32'h12BB_56DD);

    access(1'b0, 4'hF, 32'h0000_0100, 32'h0);
    checkVal("hold_en0", rdata, 32'h12BB_56DD);
    access(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checkVal("no_wr_en0", rdata, 32'h12BB_56DD);

    access(1'b1, 4'hF, 32'h0000_0200, 32'h1111_1111);
    access(1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_0000);
    checkVal("read_first", rdata, 32'h1111_1111);
    access(1'b1, 4'h0, 32'h0001_0200, 32'h0);
    checkVal("ram_alias", rdata, 32'hCAFE_0000);

    access(1'b1, 4'hF, 32'hBFAF_F000, 32'hFFFF_1234);
    checkVal("led_out", {16'h0, led}, 32'h0000_1234);
    access(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
    checkVal("led_read", rdata, 32'h0000_1234);

    access(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
    checkVal("switch_read", rdata, 32'h0000_00A5);
    access(1'b1, 4'hF, 32'hBFAF_F020, 32'h0000_0000);
    access(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
    checkVal("switch_wr_ign", rdata, 32'h0000_00A5);
    checkVal("led_kept", {16'h0, led}, 32'h0000_1234);

    access(1'b1, 4'h0, 32'hBFAF_F0F0, 32'h0);
    checkVal("unmapped", rdata, 32'h0);

    access(1'b1, 4'hF, 32'hBFAF_F010, 32'hDEAD_BEEF);
    checkVal("num_out", numData, 32'hDEAD_BEEF);
    access(1'b1, 4'b0011, 32'hBFAF_F010, 32'h0000_1357);
    checkVal("num_rd_first", rdata, 32'hDEAD_BEEF);
    access(1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
    checkVal("num_bytes", rdata, 32'hDEAD_1357);

    access(1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
    repeat (3) idle();
    access(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
    checkVal("timer_wrap", rdata, 32'h0000_0001);

    // Back-to-back NUM reads, then reset asserted mid-cycle.
    access(1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
    en = 1'b1; wen = 4'h0; addr = 32'hBFAF_F010;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkVal("arst_rdata", rdata, 32'h0);
    checkVal("arst_led", {16'h0, led}, 32'h0);
    checkVal("arst_num", numData, 32'h0);
    checkVal("arst_timer", dut.timer, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    access(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
    checkVal("timer_after_rst", rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Memory-side responder for the CPU's data SRAM-like port: accepts `data_sram_en/wen/addr/wdata` from the core and returns `data_sram_rdata` one cycle later. Decodes each access to either a byte-writable on-chip RAM or a small MMIO register page: LED, 7-segment number, switch input and a free-running timer. Sits beside the CPU top in the SoC wrapper, directly on the core's data port; the instruction port is served elsewhere.

## Interface
Parameters:
- `RAM_AW`, default 14: RAM word-address width; the RAM holds 2^RAM_AW 32-bit words.
- `MMIO_BASE`, default 16'hBFAF: value of `addr[31:16]` that selects the MMIO page.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `data_sram_en` in 1: access request this cycle.
- `data_sram_wen` in 4: byte write enables; bit i covers `wdata[8i+7:8i]`.
- `data_sram_addr` in 32: byte address; bits [1:0] are ignored.
- `data_sram_wdata` in 32: write data.
- `data_sram_rdata` out 32: read data, valid the cycle after the request.
- `switch` in 8: board switches, sampled on read.
- `led` out 16: LED register.
- `num_data` out 32: 7-segment display register.

## Operation
- Decode in the request cycle: `addr[31:16]==MMIO_BASE` selects MMIO, anything else selects RAM.
- RAM index is `addr[RAM_AW+1:2]`. Higher bits are ignored, so the RAM aliases through the address space.
- MMIO offsets, taken from `addr[15:0]`:
  - 16'hF000: LED, RW. Only bits [15:0] are stored; reads return the upper 16 bits as zero.
  - 16'hF010: NUM, RW, 32 bits.
  - 16'hF020: SWITCH, RO. Reads return `{24'b0, switch}`; writes are ignored.
  - 16'hE000: TIMER, RW, 32 bits, free-running.
  - Any other offset: reads return 0, writes are ignored.
- A write is performed only when `en=1` and `wen!=0`; each byte is written only if its `wen` bit is set. With `en=0`, `wen` is ignored.
- A read is performed whenever `en=1`, including write cycles. The RAM is read-first: a write cycle returns the contents before the write. An MMIO write cycle likewise returns the pre-write register value.
- TIMER:
  - Increments by 1 every cycle, wrapping from 0xFFFFFFFF to 0.
  - In a cycle that writes TIMER, the next value is the byte-merged write data; the written bytes take precedence over the increment.
  - A TIMER read returns the counter value present in the request cycle.
- `data_sram_rdata` is a register. It updates only on cycles with `en=1` and holds its value otherwise.

## Timing
- Read latency is exactly 1 cycle, with no stalls; one request is accepted every cycle, back-to-back.
- A write is visible to a read issued in the next cycle; no bypass is needed because the read-first RAM has already completed the write.
- Reset values: `data_sram_rdata`=0, `led`=0, `num_data`=0, TIMER=0. RAM contents are not reset.
- Reset asserted mid-stream: all registers clear immediately. A request pending at deassertion is dropped; the first legal request is in the first cycle after `reset` falls.
- `led` and `num_data` change on the edge that completes the write cycle.

## Structure
- Shared package `soc_map_pkg` holds `MMIO_BASE`, the four offset constants (LED, NUM, SWITCH, TIMER) and the default `RAM_AW`.
- One sub-module, `sp_ram_bw`: single-port, read-first, byte-write-enable RAM with registered output. The top of the block does decode, the MMIO registers, the timer, and the final rdata mux. The mux selects the RAM output when the registered decode flag shows a RAM access, and the MMIO read register otherwise.

## Test plan
- RAM word write then read: write 0x12345678 to 0x0000_0100 with wen=4'hF, then read 0x0000_0100 on the next cycle → rdata=0x12345678 one cycle later.
- Byte enables: write 0xAABBCCDD with wen=4'b0101 over a word holding 0x12345678 → read returns 0x12BB56DD.
- Read-first and alias: write 0xCAFE0000 to address A while the word holds 0x11111111 → rdata=0x11111111 in the following cycle. A subsequent read at A + 2^(RAM_AW+2) returns 0xCAFE0000.
- MMIO registers:
  - Write 0xFFFF1234 to 0xBFAF_F000 → `led`=16'h1234 the next cycle, and a read returns 0x00001234.
  - With `switch`=8'hA5, read 0xBFAF_F020 → rdata 0x000000A5.
  - Write to SWITCH → no effect.
  - Read 0xBFAF_F0F0 → 0.
- Timer: 10 cycles after reset, read TIMER → rdata=10 (counter value in the request cycle). Write 0xFFFFFFFE, idle 3 cycles, then read → 0x00000001 (wrap).
- Async reset mid-burst: assert `reset` between clock edges during back-to-back reads → `data_sram_rdata`, `led`, `num_data` and TIMER read 0 immediately, with no clock edge required.
